// File: rtl/frog_log_rider.sv
// Purpose : decides, once per movement tick, whether the frog rides a log
//           (carry_left pulse) or falls into the river (drown pulse).
// Latency : a tick sampled at edge T gives its pulse at edge T+NUM_LOGS+2.
// Backpr. : none; ticks arriving while a scan is in flight or while DEAD are dropped.
//
// Ports:
//   CLK, RESETn          clock, asynchronous active-low reset
//   enable               allows evaluation; low forces IDLE and clears riding
//   timer_done           one-cycle movement tick shared with the log movers
//   frogX, frogY         frog reference point
//   logX_flat, logY_flat log start coordinates, log i in bits [11i+10:11i]
//   log_active           per-log enable
//   respawn              leaves the DEAD state
//   carry_left, drown    registered one-cycle result pulses
//   riding, ride_idx     level: frog stands on log ride_idx
//   busy                 high while scanning or deciding
module frog_log_rider #(
  parameter int NUM_LOGS  = 4,
  parameter int LOG_LEN   = 80,
  parameter int LOG_H     = 20,
  parameter int RIVER_TOP = 80,
  parameter int RIVER_BOT = 399,
  localparam int IW       = (NUM_LOGS > 1) ? $clog2(NUM_LOGS) : 1
) (
  input  logic                   CLK,
  input  logic                   RESETn,
  input  logic                   enable,
  input  logic                   timer_done,
  input  logic [10:0]            frogX,
  input  logic [10:0]            frogY,
  input  logic [NUM_LOGS*11-1:0] logX_flat,
  input  logic [NUM_LOGS*11-1:0] logY_flat,
  input  logic [NUM_LOGS-1:0]    log_active,
  input  logic                   respawn,
  output logic                   carry_left,
  output logic                   drown,
  output logic                   riding,
  output logic [IW-1:0]          ride_idx,
  output logic                   busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_DECIDE = 2'd2,
    S_DEAD   = 2'd3
  } state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_LOGS - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;

  // Snapshot taken when a tick is accepted; the scan only ever looks at these.
  logic [10:0]             r_frog_x;
  logic [10:0]             r_frog_y;
  logic [NUM_LOGS*11-1:0]  r_log_x;
  logic [NUM_LOGS*11-1:0]  r_log_y;
  logic [NUM_LOGS-1:0]     r_log_act;

  logic [IW-1:0]           r_idx;
  logic                    r_hit;
  logic [IW-1:0]           r_hit_idx;

  // Decision is latched one cycle before it drives the output pulses, which
  // gives the fixed NUM_LOGS+2 latency and lets enable=0 cancel it.
  logic                    r_carry_pend;
  logic                    r_drown_pend;
  logic                    r_carry_left;
  logic                    r_drown;
  logic                    r_riding;
  logic [IW-1:0]           r_ride_idx;

  logic                    w_take;
  logic                    w_carry_nxt;
  logic                    w_drown_nxt;
  logic                    w_set_ride;
  logic                    w_clr_ride;

  logic [10:0]             w_lx_arr [NUM_LOGS];
  logic [10:0]             w_ly_arr [NUM_LOGS];
  logic [11:0]             w_fx12;
  logic [11:0]             w_fy12;
  logic [11:0]             w_lx12;
  logic [11:0]             w_ly12;
  logic                    w_x_ok;
  logic                    w_y_ok;
  logic                    w_hit;
  logic                    w_in_river;

  for (genvar g = 0; g < NUM_LOGS; g++) begin : g_unpack
    assign w_lx_arr[g] = r_log_x[g*11 +: 11];
    assign w_ly_arr[g] = r_log_y[g*11 +: 11];
  end

  // Hit test on the log at the current scan index. Upper bounds are formed
  // at 12 bits so a log near X=2047 does not wrap to a small value.
  always_comb begin
    w_fx12 = {1'b0, r_frog_x};
    w_fy12 = {1'b0, r_frog_y};
    w_lx12 = {1'b0, w_lx_arr[r_idx]};
    w_ly12 = {1'b0, w_ly_arr[r_idx]};
    w_x_ok = (w_lx12 <= w_fx12) && (w_fx12 <= (w_lx12 + 12'(LOG_LEN - 1)));
    w_y_ok = (w_ly12 <= w_fy12) && (w_fy12 <= (w_ly12 + 12'(LOG_H - 1)));
    w_hit  = r_log_act[r_idx] && w_x_ok && w_y_ok;
  end

  assign w_in_river = (w_fy12 >= 12'(RIVER_TOP)) && (w_fy12 <= 12'(RIVER_BOT));

  // State register
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_carry_nxt = 1'b0;
    w_drown_nxt = 1'b0;
    w_set_ride  = 1'b0;
    w_clr_ride  = 1'b0;
    if (!enable) begin
      w_state_nxt = S_IDLE;
      w_clr_ride  = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (timer_done) begin
            w_state_nxt = S_SCAN;
            w_take      = 1'b1;
          end
        end
        S_SCAN: begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_DECIDE;
          end
        end
        S_DECIDE: begin
          w_state_nxt = S_IDLE;
          if (!w_in_river) begin
            w_clr_ride = 1'b1;
          end else if (r_hit && (r_frog_x != 11'd0)) begin
            w_set_ride  = 1'b1;
            w_carry_nxt = 1'b1;
          end else begin
            // No log underneath, or a log that would carry the frog off
            // the left edge of the screen.
            w_drown_nxt = 1'b1;
            w_clr_ride  = 1'b1;
            w_state_nxt = S_DEAD;
          end
        end
        S_DEAD: begin
          if (respawn) begin
            w_state_nxt = S_IDLE;
            w_clr_ride  = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Snapshot and scan datapath
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_frog_x  <= '0;
      r_frog_y  <= '0;
      r_log_x   <= '0;
      r_log_y   <= '0;
      r_log_act <= '0;
      r_idx     <= '0;
      r_hit     <= 1'b0;
      r_hit_idx <= '0;
    end else if (w_take) begin
      r_frog_x  <= frogX;
      r_frog_y  <= frogY;
      r_log_x   <= logX_flat;
      r_log_y   <= logY_flat;
      r_log_act <= log_active;
      r_idx     <= '0;
      r_hit     <= 1'b0;
      r_hit_idx <= '0;
    end else if (r_state == S_SCAN) begin
      // Only the first hit is kept: lowest index wins.
      if (w_hit && !r_hit) begin
        r_hit     <= 1'b1;
        r_hit_idx <= r_idx;
      end
      r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
    end
  end

  // Result registers
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_carry_pend <= 1'b0;
      r_drown_pend <= 1'b0;
      r_carry_left <= 1'b0;
      r_drown      <= 1'b0;
      r_riding     <= 1'b0;
      r_ride_idx   <= '0;
    end else begin
      r_carry_pend <= w_carry_nxt;
      r_drown_pend <= w_drown_nxt;
      r_carry_left <= r_carry_pend & enable;
      r_drown      <= r_drown_pend & enable;
      if (w_clr_ride) begin
        r_riding <= 1'b0;
      end else if (w_set_ride) begin
        r_riding   <= 1'b1;
        r_ride_idx <= r_hit_idx;
      end
    end
  end

  assign carry_left = r_carry_left;
  assign drown      = r_drown;
  assign riding     = r_riding;
  assign ride_idx   = r_ride_idx;
  assign busy       = (r_state == S_SCAN) || (r_state == S_DECIDE);

endmodule

// File: tb/tb_frog_log_rider.sv
// Purpose : self-checking bench for frog_log_rider with a pulse scoreboard.
// Latency : expects each pulse exactly NUM_LOGS+2 edges after its tick.
// Backpr. : none; unexpected, late or missing pulses are all reported.
module tb_frog_log_rider;

  localparam int NL = 4;

  logic          CLK;
  logic          RESETn;
  logic          enable;
  logic          timer_done;
  logic [10:0]   frogX;
  logic [10:0]   frogY;
  logic [NL*11-1:0] logX_flat;
  logic [NL*11-1:0] logY_flat;
  logic [NL-1:0] log_active;
  logic          respawn;
  logic          carry_left;
  logic          drown;
  logic          riding;
  logic [1:0]    ride_idx;
  logic          busy;

  frog_log_rider dut (
    .CLK        (CLK),
    .RESETn     (RESETn),
    .enable     (enable),
    .timer_done (timer_done),
    .frogX      (frogX),
    .frogY      (frogY),
    .logX_flat  (logX_flat),
    .logY_flat  (logY_flat),
    .log_active (log_active),
    .respawn    (respawn),
    .carry_left (carry_left),
    .drown      (drown),
    .riding     (riding),
    .ride_idx   (ride_idx),
    .busy       (busy)
  );

  typedef struct {
    bit is_drown;
    int at;
    int idx;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic set_log(input int i, input int x, input int y, input bit a);
    logX_flat[i*11 +: 11] = 11'(x);
    logY_flat[i*11 +: 11] = 11'(y);
    log_active[i]         = a;
  endtask

  task automatic park_logs();
    for (int i = 0; i < NL; i++) set_log(i, 400, 0, 1'b1);
  endtask

  task automatic set_frog(input int x, input int y);
    frogX = 11'(x);
    frogY = 11'(y);
  endtask

  // Issue one tick at the current negedge; the edge that samples it is cyc+1,
  // so the pulse becomes visible at the negedge where cyc == cyc+1+NL+2.
  task automatic tick(input bit expect_pulse, input bit is_drown, input int idx);
    exp_t e;
    timer_done = 1'b1;
    if (expect_pulse) begin
      e.is_drown = is_drown;
      e.at       = cyc + 1 + NL + 2;
      e.idx      = idx;
      q.push_back(e);
    end
    @(negedge CLK);
    timer_done = 1'b0;
  endtask

  initial begin
    RESETn     = 1'b0;
    enable     = 1'b0;
    timer_done = 1'b0;
    respawn    = 1'b0;
    logX_flat  = '0;
    logY_flat  = '0;
    log_active = '0;
    set_frog(0, 0);

    fork
      forever begin
        @(negedge CLK);
        if (q.size() != 0 && cyc > q[0].at) begin
          mon_e = q.pop_front();
          chk("missing_pulse_at", cyc, mon_e.at);
        end
        if (carry_left || drown) begin
          chk("pulse_exclusive", int'(carry_left & drown), 0);
          if (q.size() == 0) begin
            chk("unexpected_pulse_cycle", cyc, -1);
          end else begin
            mon_e = q.pop_front();
            chk("pulse_is_drown", int'(drown), int'(mon_e.is_drown));
            chk("pulse_cycle", cyc, mon_e.at);
            if (!mon_e.is_drown) begin
              chk("ride_idx", int'(ride_idx), mon_e.idx);
              chk("riding_on_carry", int'(riding), 1);
            end else begin
              chk("riding_on_drown", int'(riding), 0);
            end
          end
        end
      end
    join_none

    // Reset state
    idle(3);
    chk("rst_carry_left", int'(carry_left), 0);
    chk("rst_drown", int'(drown), 0);
    chk("rst_riding", int'(riding), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ride_idx", int'(ride_idx), 0);
    RESETn = 1'b1;
    enable = 1'b1;
    idle(2);

    // Ride on log 2
    park_logs();
    set_log(2, 120, 100, 1'b1);
    set_frog(150, 100);
    tick(1'b1, 1'b0, 2);
    idle(1);
    chk("busy_in_scan", int'(busy), 1);
    idle(8);
    chk("ride_level", int'(riding), 1);
    chk("ride_level_idx", int'(ride_idx), 2);
    chk("busy_after", int'(busy), 0);

    // X edge: logX+79 hits
    park_logs();
    set_log(0, 71, 100, 1'b1);
    tick(1'b1, 1'b0, 0);
    idle(9);
    // X edge: logX+80 misses on log 0, log 3 picks the frog up
    park_logs();
    set_log(0, 70, 100, 1'b1);
    set_log(3, 120, 100, 1'b1);
    tick(1'b1, 1'b0, 3);
    idle(9);
    // Y edge: logY+19 hits on log 1
    park_logs();
    set_log(1, 120, 81, 1'b1);
    tick(1'b1, 1'b0, 1);
    idle(9);
    // Y edge: logY+20 misses on log 1, log 3 hits
    park_logs();
    set_log(1, 120, 80, 1'b1);
    set_log(3, 120, 100, 1'b1);
    tick(1'b1, 1'b0, 3);
    idle(9);
    // Priority: log 0 covers but inactive, logs 1 and 3 both cover
    park_logs();
    set_log(0, 120, 100, 1'b0);
    set_log(1, 100, 90, 1'b1);
    set_log(3, 150, 100, 1'b1);
    tick(1'b1, 1'b0, 1);
    idle(9);
    // Upper X bound beyond 11 bits must not wrap
    park_logs();
    set_log(0, 2000, 100, 1'b1);
    set_frog(2010, 100);
    tick(1'b1, 1'b0, 0);
    idle(9);

    // Bank: outside the river, no log -> no pulse, riding cleared
    park_logs();
    set_frog(150, 40);
    tick(1'b0, 1'b0, 0);
    idle(9);
    chk("bank_riding", int'(riding), 0);

    // Tick during SCAN is dropped: one pulse only
    set_log(2, 120, 100, 1'b1);
    set_frog(150, 100);
    tick(1'b1, 1'b0, 2);
    idle(2);
    tick(1'b0, 1'b0, 0);
    idle(10);

    // Snapshot: frog moves mid-scan, result follows the snapshot
    tick(1'b1, 1'b0, 2);
    idle(1);
    set_frog(500, 40);
    idle(9);
    set_frog(150, 100);

    // Drown: no log beneath
    park_logs();
    tick(1'b1, 1'b1, 0);
    idle(9);
    chk("dead_riding", int'(riding), 0);
    chk("dead_busy", int'(busy), 0);
    // In DEAD a tick over a log gives nothing
    set_log(2, 120, 100, 1'b1);
    tick(1'b0, 1'b0, 0);
    idle(9);
    // respawn together with a tick: back to IDLE, tick dropped
    respawn = 1'b1;
    tick(1'b0, 1'b0, 0);
    respawn = 1'b0;
    idle(9);
    // Now IDLE: a plain tick rides again
    tick(1'b1, 1'b0, 2);
    idle(9);

    // frogX=0 on a log: carried off-screen -> drown
    park_logs();
    set_log(0, 0, 100, 1'b1);
    set_frog(0, 100);
    tick(1'b1, 1'b1, 0);
    idle(9);
    // enable low in DEAD returns to IDLE
    enable = 1'b0;
    idle(1);
    enable = 1'b1;
    set_log(2, 120, 100, 1'b1);
    set_frog(150, 100);
    tick(1'b1, 1'b0, 2);
    idle(9);

    // enable low mid-scan: aborted, no pulse, busy cleared
    tick(1'b0, 1'b0, 0);
    idle(1);
    enable = 1'b0;
    idle(1);
    chk("disable_busy", int'(busy), 0);
    chk("disable_riding", int'(riding), 0);
    enable = 1'b1;
    idle(9);

    // Ride again so reset has something to clear, then reset at T+2
    tick(1'b1, 1'b0, 2);
    idle(9);
    tick(1'b0, 1'b0, 0);
    idle(1);
    RESETn = 1'b0;
    #1;
    chk("midrst_riding", int'(riding), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ride_idx", int'(ride_idx), 0);
    chk("midrst_pulse", int'(carry_left | drown), 0);
    idle(2);
    RESETn = 1'b1;
    idle(10);
    // First tick after release starts a fresh scan
    tick(1'b1, 1'b0, 2);
    idle(9);

    for (int k = 0; k < 50 && q.size() != 0; k++) @(negedge CLK);
    chk("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
